// File: rtl/fpu_add_sub_norm_round_if.sv
// fpu_add_sub_norm_round_if: operand/result handshake bundle for the FP32 add/sub normalize-round stage
interface fpu_add_sub_norm_round_if #(
  parameter int SIZE_MAN  = 24,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN - 1
);
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_sign;
  logic [SIZE_EXP-1:0]  i_exp;
  logic [SIZE_MAN-1:0]  i_man_alu;
  logic                 i_overflow;
  logic [2:0]           i_grs;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_result;
  logic                 o_ovf;
  logic                 o_unf;
  modport slave (
    input  i_valid, i_sign, i_exp, i_man_alu, i_overflow, i_grs, i_ready,
    output o_ready, o_valid, o_result, o_ovf, o_unf
  );
  modport master (
    output i_valid, i_sign, i_exp, i_man_alu, i_overflow, i_grs, i_ready,
    input  o_ready, o_valid, o_result, o_ovf, o_unf
  );
endinterface

// File: rtl/fpu_add_sub_norm_round.sv
// fpu_add_sub_norm_round: two-stage normalize/round-nearest-even/pack of the FP32 mantissa ALU result; FPU_NORM_DENORM_EN enables subnormal results (otherwise underflow flushes to zero)
module fpu_add_sub_norm_round #(
  parameter int SIZE_MAN  = 24,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN - 1
) (
  input logic i_clk,
  input logic i_rst,
  fpu_add_sub_norm_round_if.slave bus
);
  localparam int WW = SIZE_MAN + 3;
  localparam int EW = SIZE_EXP + 1;
  localparam int LW = $clog2(SIZE_MAN + 1);
  localparam logic [EW-1:0] EMAX = EW'({SIZE_EXP{1'b1}});
  logic v1, v2, adv1, adv2;
  logic [WW-1:0] w_in, w_nxt, w1;
  logic [EW-1:0] e_in, e_nxt, e1, lz_e, e_rnd;
  logic [LW-1:0] lz;
  logic s1, z1, u1, unf_nxt, zero_nxt;
  logic [SIZE_MAN-1:0] m1, m_rnd;
  logic [SIZE_MAN:0] sum;
  logic up, carry, inf, unf_rnd, flush;
  logic [SIZE_DATA-1:0] res_nxt;
  assign adv2 = ~v2 | bus.i_ready;
  assign adv1 = ~v1 | adv2;
  assign bus.o_ready = adv1;
  assign bus.o_valid = v2;
  assign w_in = {bus.i_man_alu, bus.i_grs};
  assign e_in = {1'b0, bus.i_exp};
  assign lz_e = EW'(lz);
  assign zero_nxt = ~bus.i_overflow & ~|bus.i_man_alu;
  // leading-zero count of the ALU mantissa; the highest set bit wins
  always_comb begin
    lz = LW'(SIZE_MAN);
    for (int i = 0; i < SIZE_MAN; i++) if (bus.i_man_alu[i]) lz = LW'(SIZE_MAN - 1 - i);
  end
  // normalize: carry right-shift, leading-zero left-shift, or clamp at the subnormal boundary
  always_comb begin
    unf_nxt = 1'b0;
    if (bus.i_overflow) begin
      w_nxt = {1'b1, bus.i_man_alu, bus.i_grs[2], |bus.i_grs[1:0]};
      e_nxt = e_in + EW'(1);
    end else if (e_in > lz_e) begin
      w_nxt = w_in << lz;
      e_nxt = e_in - lz_e;
    end else begin
`ifdef FPU_NORM_DENORM_EN
      w_nxt = w_in << (e_in - EW'(1));
`else
      w_nxt = w_in;
`endif
      e_nxt = '0;
      unf_nxt = 1'b1;
    end
  end
  // stage 1 register: refills whenever its slot is empty or draining into stage 2
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      w1 <= '0;
      e1 <= '0;
      s1 <= 1'b0;
      z1 <= 1'b0;
      u1 <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.i_valid;
      if (bus.i_valid) begin
        w1 <= w_nxt;
        e1 <= e_nxt;
        s1 <= bus.i_sign & ~zero_nxt;
        z1 <= zero_nxt;
        u1 <= unf_nxt & ~zero_nxt;
      end
    end
  end
  assign m1 = w1[WW-1:3];
  assign up = w1[2] & (w1[1] | w1[0] | m1[0]);
  assign sum = {1'b0, m1} + (SIZE_MAN+1)'(up);
  assign carry = sum[SIZE_MAN];
  assign m_rnd = carry ? sum[SIZE_MAN:1] : sum[SIZE_MAN-1:0];
  assign e_rnd = e1 + EW'(carry) + EW'(e1 == '0 && sum[SIZE_MAN-1]);
  assign unf_rnd = u1 & (e_rnd == '0);
  assign inf = e_rnd >= EMAX;
`ifdef FPU_NORM_DENORM_EN
  assign flush = 1'b0;
`else
  assign flush = u1;
`endif
  assign res_nxt = (z1 | flush) ? {s1, {(SIZE_DATA-1){1'b0}}} :
                   inf ? {s1, {SIZE_EXP{1'b1}}, {(SIZE_MAN-1){1'b0}}} :
                   {s1, e_rnd[SIZE_EXP-1:0], m_rnd[SIZE_MAN-2:0]};
  // stage 2 register: rounded, packed result held while downstream stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2 <= 1'b0;
      bus.o_result <= '0;
      bus.o_ovf <= 1'b0;
      bus.o_unf <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        bus.o_result <= res_nxt;
        bus.o_ovf <= ~z1 & ~flush & inf;
        bus.o_unf <= ~z1 & (flush | (~inf & unf_rnd));
      end
    end
  end
endmodule

// File: doc/fpu_add_sub_norm_round.md
Name: fpu_add_sub_norm_round

Overview:
- Post-ALU stage of the FP32 adder/subtractor; consumes the raw mantissa sum/difference and carry-out from the mantissa ALU plus the larger operand's exponent and sign.
- Normalizes (carry right-shift or leading-zero left-shift), rounds to nearest-even, handles exponent overflow/underflow, and packs an IEEE-754 single.
- Two-stage pipeline with valid/ready handshake, so it sits between the combinational ALU and the FFT butterfly result registers.

Parameters:
- SIZE_MAN, 24, mantissa width incl. hidden bit (ALU output width)
- SIZE_EXP, 8, exponent width
- SIZE_DATA, 32, packed result width = 1 + SIZE_EXP + SIZE_MAN - 1

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_valid  in  1  upstream operand valid
- o_ready  out  1  stage can accept an operand this cycle
- i_sign  in  1  result sign (sign of larger-magnitude operand)
- i_exp  in  SIZE_EXP  effective biased exponent of larger operand, range 1..254
- i_man_alu  in  SIZE_MAN  ALU mantissa result, hidden-bit position [SIZE_MAN-1]
- i_overflow  in  1  ALU carry-out (add only)
- i_grs  in  3  guard/round/sticky bits shifted out during alignment
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  SIZE_DATA  packed {sign, exp, frac}
- o_ovf  out  1  result overflowed to infinity
- o_unf  out  1  result underflowed (subnormal or flushed)

Behaviour:
- Reset: v1=v2=0, o_valid=0, o_result=0, o_ovf=0, o_unf=0, o_ready=1. Reset mid-operation discards all in-flight data.
- Handshake: adv2 = ~v2 | i_ready; adv1 = ~v1 | adv2; o_ready = adv1. Input is accepted on i_valid & o_ready. Output transfers on o_valid & i_ready. Outputs are held stable while o_valid & ~i_ready. Full throughput is 1/cycle; latency is exactly 2 cycles when i_ready=1.
- Stage 1 (normalize), operating on the 27-bit working value W = {man, grs}:
  - i_overflow=1: W' = {1, man, g} >> 1 with the sticky ORed with dropped bits; exp+1.
  - i_overflow=0 & man==0: exact zero; result forced to +0 (sign 0), flags 0.
  - Else n = leading-zero count of man (0..23).
    - If i_exp > n: W <<= n, exp -= n.
    - Else (underflow): W <<= (i_exp-1), exp = 0, unf=1.
  - Registers W', exp (SIZE_EXP+1 bits), sign, zero flag, unf.
- Stage 2 (round/pack):
  - Round-nearest-even: up = G & (R | S | LSB).
  - Mantissa increment carry-out (0xFFFFFF+1) → mantissa 0x800000, exp+1.
  - Subnormal rounding up to 0x800000 → exp=1 (normal), unf is cleared.
  - exp ≥ 255 after any step → o_result = {sign, 0xFF, 0}, o_ovf=1.
  - Frac field = mantissa[22:0].
- Simultaneous accept and release with both stages full is legal; no bubble is inserted.

Optional Feature:
- FPU_NORM_DENORM_EN
  - Defined: underflow produces a correctly rounded subnormal, as above.
  - Undefined: underflow path flushes to {sign, 0, 0}, o_unf=1, no rounding, and the stage-1 underflow shifter is omitted.

Test Plan:
- 1.0+1.0: i_sign=0, i_exp=127, i_man_alu=0x000000, i_overflow=1, i_grs=0 → 2 cycles later o_result=0x40000000, o_ovf=0.
- 1.0-0.75: i_exp=127, i_man_alu=0x200000, i_overflow=0, i_grs=0 → o_result=0x3E800000.
- Exact cancel: i_sign=1, i_man_alu=0, i_overflow=0 → o_result=0x00000000.
- Round carry: i_exp=127, i_man_alu=0xFFFFFF, i_grs=3'b100 → o_result=0x40000000. Same with i_man_alu=0xFFFFFE → 0x3FFFFFFE (tie to even, no round-up).
- Overflow: i_exp=254, i_overflow=1, i_man_alu=0x000000 → o_result=0x7F800000, o_ovf=1.
- Backpressure: send 3 back-to-back operands with i_ready=0 → o_ready drops after 2 accepts and o_result stays constant. Raise i_ready → results emerge in order, one per cycle. Assert i_rst mid-stream → o_valid=0 the next cycle.
